// File: rtl/bcd_to_binary_serial.sv
// Serial BCD-to-binary decoder using reverse Double-Dabble, one iteration per clock.
// Valid/ready handshakes on both sides; every output comes straight from a flop.
module bcd_to_binary_serial #(
    parameter int unsigned WIDTH_BCD    = 12,
    parameter int unsigned WIDTH_BINARY = 10
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    input_valid,
    output logic                    input_ready,
    input  logic [WIDTH_BCD-1:0]    input_bcd,
    output logic                    output_valid,
    input  logic                    output_ready,
    output logic [WIDTH_BINARY-1:0] output_binary,
    output logic                    output_overflow,
    output logic                    output_invalid
);

    localparam int unsigned NUM_DIGITS    = WIDTH_BCD / 4;
    localparam int unsigned WIDTH_SCRATCH = WIDTH_BCD + WIDTH_BINARY;
    localparam int unsigned WIDTH_COUNT   = $clog2(WIDTH_BINARY + 1);

    generate
        if ((WIDTH_BCD % 4) != 0 || WIDTH_BCD == 0) begin : g_bad_bcd_width
            $error("WIDTH_BCD must be a non-zero multiple of 4");
        end
        if (WIDTH_BINARY < 1) begin : g_bad_binary_width
            $error("WIDTH_BINARY must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                   state;
    logic [WIDTH_SCRATCH-1:0] scratch;
    logic [WIDTH_COUNT-1:0]   count;
    logic                     invalid;

    logic [WIDTH_SCRATCH-1:0] shifted_c;
    logic [WIDTH_SCRATCH-1:0] adjusted_c;
    logic                     digits_bad_c;

    // One reverse Double-Dabble step, plus the digit range check on the incoming word.
    always_comb begin
        shifted_c    = scratch >> 1;
        adjusted_c   = shifted_c;
        digits_bad_c = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (shifted_c[WIDTH_BINARY + 4*i +: 4] >= 4'd8) begin
                adjusted_c[WIDTH_BINARY + 4*i +: 4] = shifted_c[WIDTH_BINARY + 4*i +: 4] - 4'd3;
            end
            digits_bad_c = digits_bad_c | (input_bcd[4*i +: 4] > 4'd9);
        end
    end

    // The counter runs 0..WIDTH_BINARY; the final count value is the evaluation
    // cycle that loads the result registers, so DONE begins one edge after the
    // last iteration.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            scratch         <= '0;
            count           <= '0;
            invalid         <= 1'b0;
            input_ready     <= 1'b1;
            output_valid    <= 1'b0;
            output_binary   <= '0;
            output_overflow <= 1'b0;
            output_invalid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (input_valid) begin
                        scratch     <= {input_bcd, {WIDTH_BINARY{1'b0}}};
                        count       <= '0;
                        invalid     <= digits_bad_c;
                        state       <= CONVERT;
                        input_ready <= 1'b0;
                    end
                end
                CONVERT: begin
                    if (count == WIDTH_COUNT'(WIDTH_BINARY)) begin
                        state           <= DONE;
                        output_valid    <= 1'b1;
                        output_binary   <= invalid ? '0 : scratch[WIDTH_BINARY-1:0];
                        output_overflow <= !invalid && (|scratch[WIDTH_SCRATCH-1:WIDTH_BINARY]);
                        output_invalid  <= invalid;
                    end else begin
                        scratch <= adjusted_c;
                        count   <= count + WIDTH_COUNT'(1);
                    end
                end
                DONE: begin
                    if (output_ready) begin
                        state        <= IDLE;
                        output_valid <= 1'b0;
                        input_ready  <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    output_valid <= 1'b0;
                    input_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
